// File: rtl/cont_cresc_cinco.sv
// Session timer: counts 0..5 once per Start, with pause/abort control.
// It pulses Done on completion and keeps a saturating count of finished sessions.
module cont_cresc_cinco (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Stop,
    output logic       Q2,
    output logic       Q1,
    output logic       Q0,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Sessions
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_reg;
    logic [2:0] count_reg;
    logic       busy_reg;
    logic       done_reg;
    logic [3:0] sessions_reg;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg    <= IDLE;
            count_reg    <= 3'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sessions_reg <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_reg <= 3'd0;
                    done_reg  <= 1'b0;
                    if (Start) begin
                        state_reg <= COUNT;
                        busy_reg  <= 1'b1;
                    end else begin
                        busy_reg  <= 1'b0;
                    end
                end
                COUNT: begin
                    // Stop outranks Pause, which outranks counting.
                    if (Stop) begin
                        state_reg <= IDLE;
                        count_reg <= 3'd0;
                        busy_reg  <= 1'b0;
                    end else if (Pause) begin
                        state_reg <= PAUSED;
                    end else if (count_reg == 3'd5) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        if (sessions_reg != 4'd15)
                            sessions_reg <= sessions_reg + 4'd1;
                    end else begin
                        count_reg <= count_reg + 3'd1;
                    end
                end
                PAUSED: begin
                    // Resuming spends one edge without incrementing.
                    if (Stop) begin
                        state_reg <= IDLE;
                        count_reg <= 3'd0;
                        busy_reg  <= 1'b0;
                    end else if (!Pause) begin
                        state_reg <= COUNT;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    count_reg <= 3'd0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= 3'd0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Q2       = count_reg[2];
    assign Q1       = count_reg[1];
    assign Q0       = count_reg[0];
    assign Busy     = busy_reg;
    assign Done     = done_reg;
    assign Sessions = sessions_reg;

endmodule

// File: tb/tb_cont_cresc_cinco.sv
// Scoreboard bench for cont_cresc_cinco: a session-level reference model
// predicts outputs per edge; a monitor compares after every rising edge.
module tb_cont_cresc_cinco;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic       Pause;
    logic       Stop;
    logic       Q2, Q1, Q0;
    logic       Busy;
    logic       Done;
    logic [3:0] Sessions;

    cont_cresc_cinco dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Pause    (Pause),
        .Stop     (Stop),
        .Q2       (Q2),
        .Q1       (Q1),
        .Q0       (Q0),
        .Busy     (Busy),
        .Done     (Done),
        .Sessions (Sessions)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected outputs packed as {count[2:0], busy, done, sessions[3:0]}.
    logic [8:0] exp_q[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         cycle_no   = 0;
    bit         armed      = 0;

    // Model: position in session (-1 idle, 0..5 counting, 6 completion cycle),
    // a paused flag and number of completed sessions as a plain integer.
    int pos      = -1;
    bit paused   = 0;
    int sessions = 0;

    task automatic model_step(input bit s, input bit p, input bit st, input bit r);
        int cnt;
        if (!r) begin
            pos = -1; paused = 0; sessions = 0;
        end else if (pos == -1) begin
            if (s) begin pos = 0; paused = 0; end
        end else if (pos == 6) begin
            pos = -1;
        end else if (st) begin
            pos = -1; paused = 0;
        end else if (p) begin
            paused = 1;
        end else if (paused) begin
            paused = 0;
        end else if (pos < 5) begin
            pos = pos + 1;
        end else begin
            pos = 6;
            sessions = (sessions >= 15) ? 15 : sessions + 1;
        end
        cnt = (pos < 0) ? 0 : ((pos > 5) ? 5 : pos);
        exp_q.push_back({cnt[2:0], pos >= 0, pos == 6, sessions[3:0]});
    endtask

    task automatic cyc(input bit s, input bit p, input bit st, input bit r);
        @(negedge Clk);
        Start = s; Pause = p; Stop = st; Rst = r;
        model_step(s, p, st, r);
        armed = 1;
    endtask

    task automatic session();
        cyc(1, 0, 0, 1);
        repeat (7) cyc(0, 0, 0, 1);
    endtask

    // Monitor: one comparison per rising edge once stimulus is flowing.
    initial begin
        logic [8:0] exp_v, act_v;
        forever begin
            @(posedge Clk);
            #1;
            if (armed) begin
                cycle_no++;
                act_v = {Q2, Q1, Q0, Busy, Done, Sessions};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL outputs cyc %0d: no expectation queued, got q=%0d busy=%0b done=%0b sess=%0d",
                             cycle_no, act_v[8:6], act_v[5], act_v[4], act_v[3:0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        mismatched++;
                        $display("FAIL outputs cyc %0d: got q=%0d busy=%0b done=%0b sess=%0d, want q=%0d busy=%0b done=%0b sess=%0d",
                                 cycle_no, act_v[8:6], act_v[5], act_v[4], act_v[3:0],
                                 exp_v[8:6], exp_v[5], exp_v[4], exp_v[3:0]);
                    end else begin
                        $display("cyc %0d: in s=%0b p=%0b st=%0b r=%0b out q=%0d busy=%0b done=%0b sess=%0d",
                                 cycle_no, Start, Pause, Stop, Rst,
                                 act_v[8:6], act_v[5], act_v[4], act_v[3:0]);
                    end
                end
            end
        end
    end

    initial begin
        Rst = 1'b0; Start = 1'b0; Pause = 1'b0; Stop = 1'b0;

        // Reset held with noisy inputs must keep every output at zero.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 0);

        // First released edge already accepts Start.
        session();

        // Pause three cycles at count 2, then resume.
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 1, 0, 1);
        repeat (7) cyc(0, 0, 0, 1);

        // Stop together with Pause at count 3.
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 1);
        repeat (2) cyc(0, 0, 0, 1);

        // Stop while paused.
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 0, 0, 1);

        // Held Start: back-to-back sessions, no retrigger while busy.
        repeat (20) cyc(1, 0, 0, 1);
        repeat (8) cyc(0, 0, 0, 1);

        // Mid-session reset at count 4, then a clean session.
        cyc(1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        session();

        // Saturation: 17 sessions, Sessions must stick at 15.
        repeat (17) session();
        cyc(0, 1, 1, 1);

        // Ignored inputs during the completion cycle.
        cyc(1, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 1);
        cyc(1, 1, 1, 1);
        cyc(0, 0, 0, 1);

        // Randomized traffic with occasional resets.
        repeat (400) cyc(($urandom_range(3) == 0), ($urandom_range(4) == 0),
                         ($urandom_range(15) == 0), ($urandom_range(39) != 0));

        @(posedge Clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, compared=%0d", compared);
        $fatal(1, "timeout");
    end

endmodule
